// File: rtl/elementwise_op_pkg.sv
// Shared types and helpers for the element-wise adder slice.
package elementwise_op_pkg;

    // Per-element schedule phases plus the terminal DONE state.
    typedef enum logic [2:0] {
        P0   = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        DONE = 3'd4
    } phase_e;

    // Address width for a memory of the given depth (never narrower than 1 bit).
    function automatic int addr_width(input int depth);
        return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
    endfunction

endpackage

// File: rtl/elementwise_op_unit_result_store.sv
// Result memory: register array with async clear, unconditional write every
// clock at wr_addr_i, and a combinational read port.
module elementwise_op_unit_result_store
    import elementwise_op_pkg::*;
#(
    parameter int MEM_DEPTH = 8,
    parameter int MEM_WIDTH = 32,
    parameter int ADDR_W    = addr_width(MEM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [MEM_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [MEM_WIDTH-1:0] rd_data_o
);

    logic [MEM_WIDTH-1:0] mem_r [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] rd_data_s;

    // Clear on reset; otherwise rewrite the addressed entry on every edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                if (wr_addr_i == ADDR_W'(i)) begin
                    mem_r[i] <= wr_data_i;
                end
            end
        end
    end

    // Read mux built as an OR of matching entries so out-of-range addresses read as zero.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            rd_data_s = rd_data_s | ((rd_addr_i == ADDR_W'(i)) ? mem_r[i] : {MEM_WIDTH{1'b0}});
        end
    end

    assign rd_data_o = rd_data_s;

endmodule

// File: rtl/elementwise_op_unit.sv
// Sequential element-wise adder: walks indices 0..MEM_DEPTH-1, one element
// every four clocks, and commits operand1[i] + operand2[i] to the result store.
module elementwise_op_unit
    import elementwise_op_pkg::*;
#(
    parameter int MEM_DEPTH = 8,
    parameter int MEM_WIDTH = 32,
    localparam int ADDR_W   = addr_width(MEM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [MEM_WIDTH-1:0] operand1_i,
    input  logic [MEM_WIDTH-1:0] operand2_i,
    output logic [ADDR_W-1:0]    operand1_addr_o,
    output logic [ADDR_W-1:0]    operand2_addr_o,
    output logic [ADDR_W-1:0]    result_addr_o,
    output logic [MEM_WIDTH-1:0] result_o,
    output logic                 done_o,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [MEM_WIDTH-1:0] rd_data_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);

    phase_e               phase_r;
    logic [ADDR_W-1:0]    idx_r;
    logic [MEM_WIDTH-1:0] op1_r;
    logic [MEM_WIDTH-1:0] op2_r;
    logic [MEM_WIDTH-1:0] result_r;
    logic [ADDR_W-1:0]    result_addr_r;
    logic                 done_r;
    logic [MEM_WIDTH-1:0] sum_s;

    // Modular sum of the latched operands; the carry out is dropped.
    always_comb begin
        sum_s = op1_r + op2_r;
    end

    // Index/phase sequencer with operand latches and registered result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_r       <= P0;
            idx_r         <= '0;
            op1_r         <= '0;
            op2_r         <= '0;
            result_r      <= '0;
            result_addr_r <= '0;
            done_r        <= 1'b0;
        end else begin
            case (phase_r)
                P0: begin
                    phase_r <= P1;
                end
                P1: begin
                    op1_r   <= operand1_i;
                    op2_r   <= operand2_i;
                    phase_r <= P2;
                end
                P2: begin
                    result_r      <= sum_s;
                    result_addr_r <= idx_r;
                    phase_r       <= P3;
                end
                P3: begin
                    if (idx_r == LAST_IDX) begin
                        done_r  <= 1'b1;
                        phase_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + ADDR_W'(1);
                        phase_r <= P0;
                    end
                end
                DONE: begin
                    phase_r <= DONE;
                end
                default: begin
                    // Unused encodings: restart the sweep cleanly.
                    phase_r <= P0;
                    idx_r   <= '0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign operand1_addr_o = idx_r;
    assign operand2_addr_o = idx_r;
    assign result_addr_o   = result_addr_r;
    assign result_o        = result_r;
    assign done_o          = done_r;

    elementwise_op_unit_result_store #(
        .MEM_DEPTH (MEM_DEPTH),
        .MEM_WIDTH (MEM_WIDTH),
        .ADDR_W    (ADDR_W)
    ) u_result_store (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_addr_i (result_addr_r),
        .wr_data_i (result_r),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o)
    );

endmodule

// File: tb/tb_elementwise_op_unit.sv
// Scoreboard bench for elementwise_op_unit (MEM_DEPTH=8, MEM_WIDTH=32).
module tb_elementwise_op_unit;

    localparam int DEPTH = 8;
    localparam int W     = 32;

    typedef struct packed {
        logic [2:0]   addr;
        logic [W-1:0] data;
    } exp_t;

    typedef struct packed {
        logic         is_mem;
        logic [2:0]   addr;
        logic [W-1:0] data;
        logic         done;
    } req_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic [2:0]   operand1_addr;
    logic [2:0]   operand2_addr;
    logic [2:0]   result_addr;
    logic [W-1:0] result;
    logic         done;
    logic [2:0]   rd_addr = 3'd0;
    logic [W-1:0] rd_data;

    logic [W-1:0] op1_mem [DEPTH];
    logic [W-1:0] op2_mem [DEPTH];

    exp_t exp_q [$];
    req_t req_q [$];

    int tests = 0;
    int fails = 0;
    int edge_cnt;

    exp_t e_m;
    req_t r_m;
    logic exp_done_m;

    elementwise_op_unit #(.MEM_DEPTH(DEPTH), .MEM_WIDTH(W)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .operand1_i      (operand1),
        .operand2_i      (operand2),
        .operand1_addr_o (operand1_addr),
        .operand2_addr_o (operand2_addr),
        .result_addr_o   (result_addr),
        .result_o        (result),
        .done_o          (done),
        .rd_addr_i       (rd_addr),
        .rd_data_o       (rd_data)
    );

    always #5 clk = ~clk;

    assign operand1 = op1_mem[operand1_addr];
    assign operand2 = op2_mem[operand2_addr];

    // Rising edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Monitor: done level, per-element results, and queued memory/output checks.
    always begin
        @(negedge clk);
        exp_done_m = rst_n && (edge_cnt >= 32);
        tests++;
        if (done !== exp_done_m) begin
            fails++;
            $display("FAIL done at edge %0d: got %b, expected %b", edge_cnt, done, exp_done_m);
        end
        if (rst_n && (edge_cnt % 4 == 3) && (edge_cnt <= 31)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL result at edge %0d: got a result, expected none queued", edge_cnt);
            end else begin
                e_m = exp_q.pop_front();
                if (result !== e_m.data || result_addr !== e_m.addr || operand1_addr !== e_m.addr) begin
                    fails++;
                    $display("FAIL result at edge %0d: got addr %0d data %h opaddr %0d, expected addr %0d data %h",
                             edge_cnt, result_addr, result, operand1_addr, e_m.addr, e_m.data);
                end
            end
        end
        #1;
        for (int r = 0; r < 2; r++) begin
            if (req_q.size() > 0) begin
                r_m = req_q.pop_front();
                tests++;
                if (r_m.is_mem) begin
                    rd_addr = r_m.addr;
                    #1;
                    if (rd_data !== r_m.data) begin
                        fails++;
                        $display("FAIL mem[%0d]: got %h, expected %h", r_m.addr, rd_data, r_m.data);
                    end
                end else begin
                    if (result !== r_m.data || result_addr !== r_m.addr || done !== r_m.done ||
                        operand1_addr !== r_m.addr || operand2_addr !== r_m.addr) begin
                        fails++;
                        $display("FAIL outputs: got res %h raddr %0d done %b op %0d/%0d, expected res %h addr %0d done %b",
                                 result, result_addr, done, operand1_addr, operand2_addr,
                                 r_m.data, r_m.addr, r_m.done);
                    end
                end
            end
        end
    end

    task automatic push_mem(input int a, input logic [W-1:0] d);
        req_q.push_back('{is_mem: 1'b1, addr: 3'(a), data: d, done: 1'b0});
    endtask

    task automatic push_out(input int a, input logic [W-1:0] d, input logic dn);
        req_q.push_back('{is_mem: 1'b0, addr: 3'(a), data: d, done: dn});
    endtask

    // Golden sum of the current operand tables at index i.
    function automatic logic [W-1:0] model(input int i);
        logic [W-1:0] s;
        s = op1_mem[i] + op2_mem[i];
        return s;
    endfunction

    task automatic push_all_expected();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{addr: 3'(i), data: model(i)});
        end
    endtask

    task automatic wait_cnt(input int n);
        int k;
        k = 0;
        while (edge_cnt != n) begin
            @(negedge clk);
            k++;
            if (k > 2000) begin
                $display("FAIL wait_cnt: edge count %0d, expected to reach %0d", edge_cnt, n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (req_q.size() > 0) begin
            @(negedge clk);
            k++;
            if (k > 100) begin
                $display("FAIL drain: %0d checks pending, expected 0", req_q.size());
                $fatal(1, "timeout");
            end
        end
        #4;
    endtask

    // Stimulus.
    initial begin
        // Run 1: basic sweep op1=i, op2=10*i.
        for (int i = 0; i < DEPTH; i++) begin
            op1_mem[i] = W'(i);
            op2_mem[i] = W'(10 * i);
        end
        push_out(0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) push_mem(i, 32'h0);
        push_all_expected();
        #20 rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wait_cnt(4 * i + 4);
            push_mem(i, W'(11 * i));
        end
        push_out(7, 32'd77, 1'b1);
        wait_cnt(40);
        for (int i = 0; i < DEPTH; i++) push_mem(i, W'(11 * i));
        drain();

        // Run 2: overflow at index 3, mid-run reset, operand glitch, hold after done.
        @(negedge clk);
        #2 rst_n = 1'b0;
        op1_mem[3] = 32'hFFFF_FFFF;
        op2_mem[3] = 32'h0000_0002;
        push_all_expected();
        @(negedge clk);
        #2 rst_n = 1'b1;

        wait_cnt(23);
        #2 rst_n = 1'b0;
        exp_q.delete();
        push_out(0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) push_mem(i, 32'h0);
        drain();
        push_all_expected();
        @(negedge clk);
        #2 rst_n = 1'b1;

        wait_cnt(10);
        op1_mem[2] = 32'hDEAD_BEEF;
        wait_cnt(12);
        push_mem(2, 32'd22);
        op1_mem[2] = 32'd2;
        wait_cnt(16);
        push_mem(3, 32'h0000_0001);

        wait_cnt(42);
        push_out(7, 32'd77, 1'b1);
        push_mem(0, 32'd0);
        push_mem(1, 32'd11);
        push_mem(2, 32'd22);
        push_mem(3, 32'd1);
        push_mem(4, 32'd44);
        push_mem(5, 32'd55);
        push_mem(6, 32'd66);
        push_mem(7, 32'd77);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
